cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Run controller/monitor on the far side of PL_CPU's (PC, input_clk, rst, cycles_consumed) interface.
//  - Drives the CPU reset.
//  - Watches PC and the hlt indication, counts executed cycles and detects halt or watchdog timeout.
//  - Presents a one-shot result (cycle count and status) over a valid/ready handshake to the host or bench.
// PARAMETERS
//  MAX_CLOCKS    200000  watchdog limit, counted in RUN cycles
//  RESET_CYCLES  2       cycles cpu_rst is held after rst falls (>=1)
//  HALT_STABLE   8       consecutive unchanged-PC cycles treated as halt; must exceed the longest stall
//  CNT_W         32      width of the cycle counter and of cycles_consumed
// PORTS
//  input_clk        in   1      single clock; all logic on its rising edge
//  rst              in   1      synchronous, active-high reset
//  cpu_PC           in   32     PC output of the CPU
//  cpu_hlt          in   1      1 = hlt instruction reached WB (explicit halt)
//  cpu_rst          out  1      reset driven to the CPU
//  running          out  1      1 while in RUN
//  done             out  1      sticky; halt detected
//  timeout          out  1      sticky; watchdog expired
//  cycles_consumed  out  CNT_W  cycle count frozen at end of run
//  result_valid     out  1      result available
//  result_ready     in   1      consumer accepts the result
// BEHAVIOUR
//  Reset, synchronous:
//  - While rst=1: state=HOLD, hold_cnt=0, cnt=0, stable_cnt=0.
//  - Outputs: cpu_rst=1, running=0, done=0, timeout=0, cycles_consumed=0, result_valid=0.
//  - rst asserted mid-run or after DONE/TIMEOUT returns to HOLD on the next edge and discards the result.
//  States: HOLD -> RUN -> {DONE | TIMEOUT}. DONE and TIMEOUT are terminal until rst.
//  HOLD:
//  - cpu_rst=1; hold_cnt increments each cycle.
//  - When hold_cnt==RESET_CYCLES-1, go to RUN; cpu_rst=0 from the first RUN cycle.
//  RUN:
//  - running=1; cnt increments every cycle (first RUN cycle counts as 1).
//  - cnt saturates at 2^CNT_W-1 and never wraps.
//  - prev_PC is registered every cycle.
//  - On cpu_PC!=prev_PC: stable_cnt=0 and last_chg=cnt. Otherwise stable_cnt increments, saturating at HALT_STABLE.
//  Halt condition: cpu_hlt=1, or stable_cnt reaches HALT_STABLE-1 with PC still unchanged.
//  - Next state DONE.
//  - cycles_consumed = (cpu_hlt ? cnt : last_chg) + 1; the +1 accounts for the uncounted hlt.
//  Timeout condition: cnt==MAX_CLOCKS-1 and no halt that cycle.
//  - Next state TIMEOUT; cycles_consumed = MAX_CLOCKS.
//  Halt and timeout in the same cycle: halt wins; done=1, timeout=0.
//  DONE/TIMEOUT:
//  - done or timeout =1 and running=0.
//  - cycles_consumed frozen; cpu_rst held 1 to freeze the CPU.
//  - result_valid rises on the entry edge, i.e. 1 cycle after the detecting cycle.
//  Handshake:
//  - result_valid stays high until result_valid&&result_ready on an edge, then drops to 0 and never reasserts before rst.
//  - result_ready while result_valid=0 is ignored.
//  - Data is stable while result_valid=1.
//  Latency: detection to done/result_valid = 1 cycle; rst fall to cpu_rst fall = RESET_CYCLES cycles.
// STRUCTURE
//  Package cpu_mon_pkg holds:
//  - state encoding localparams ST_HOLD, ST_RUN, ST_DONE, ST_TIMEOUT (2 bits);
//  - defaults DEF_MAX_CLOCKS, DEF_HALT_STABLE and PC_W=32.
//  Sub-module pc_stability_detector:
//  - inputs: input_clk, rst, enable, cpu_PC;
//  - outputs: pc_stable (stable_cnt hit), changed pulse.
//  Top level holds the FSM, counters, result register and handshake.
// TESTING
//  1. rst high 3 cycles, RESET_CYCLES=2 -> cpu_rst=1 through 2 cycles after rst falls; running=1 on the next cycle.
//  2. PC steps by 4 for 10 cycles, then cpu_hlt=1 at cnt=10 -> done=1, cycles_consumed=11, result_valid=1 on the next edge.
//  3. PC steps 5 times (last change at cnt=5), then holds; HALT_STABLE=8 -> done after 8 stable cycles, cycles_consumed=6.
//     A 3-cycle stall earlier must not halt.
//  4. MAX_CLOCKS=50, PC always changing -> timeout=1 and cycles_consumed=50 at cnt=49+1; done=0.
//     Repeat with cpu_hlt=1 at cnt=49 -> done=1, timeout=0.
//  5. result_ready low 5 cycles after result_valid -> valid and data held; ready=1 -> valid drops next edge and stays 0.
//  6. rst asserted at cnt=20 in RUN -> next edge: HOLD, cnt=0, cpu_rst=1; the new run counts from 1.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared constants and state encoding for the CPU run monitor.
package cpu_mon_pkg;

    localparam int unsigned PC_W             = 32;
    localparam int unsigned DEF_MAX_CLOCKS   = 200000;
    localparam int unsigned DEF_HALT_STABLE  = 8;
    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam int unsigned DEF_CNT_W        = 32;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_run_monitor_pc_stability_detector.sv
// Flags a PC change each cycle and reports when the PC has stayed put long enough to count as a halt.
module pc_stability_detector
    import cpu_mon_pkg::*;
#(
    parameter int unsigned HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic            input_clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic [PC_W-1:0] cpu_pc_i,
    output logic            pc_stable_c,
    output logic            changed_c
);

    localparam int unsigned       STB_W   = $clog2(HALT_STABLE + 1);
    localparam logic [STB_W-1:0]  STB_MAX = STB_W'(HALT_STABLE);
    localparam logic [STB_W-1:0]  STB_HIT = STB_W'(HALT_STABLE - 1);

    logic [PC_W-1:0]  prev_pc_q;
    logic [STB_W-1:0] stable_q;
    logic [STB_W-1:0] stable_d;
    logic             same_c;

    // Run length of unchanged PC; cleared outside RUN so every run starts fresh.
    always_comb begin
        same_c      = (cpu_pc_i == prev_pc_q);
        changed_c   = enable_i && !same_c;
        pc_stable_c = enable_i && same_c && (stable_q >= STB_HIT);
        stable_d    = '0;
        if (enable_i && same_c) begin
            stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
        end
    end

    always_ff @(posedge input_clk) begin
        if (rst) begin
            prev_pc_q <= '0;
            stable_q  <= '0;
        end else begin
            prev_pc_q <= cpu_pc_i;
            stable_q  <= stable_d;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Holds the CPU in reset, runs it, detects halt or watchdog expiry and hands back a one-shot result.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int unsigned MAX_CLOCKS   = DEF_MAX_CLOCKS,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned HALT_STABLE  = DEF_HALT_STABLE,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             input_clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  cpu_PC,
    input  logic             cpu_hlt,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles_consumed,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int unsigned       HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CLOCKS - 1);
    localparam logic [CNT_W-1:0]  CNT_TOTAL = CNT_W'(MAX_CLOCKS);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_chg_q, last_chg_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              valid_q, valid_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              run_c, halt_c, pc_stable_c, changed_c;
    logic [CNT_W-1:0]  end_cnt_c;

    assign run_c = (state_q == ST_RUN);

    pc_stability_detector #(
        .HALT_STABLE (HALT_STABLE)
    ) u_pc_stab (
        .input_clk   (input_clk),
        .rst         (rst),
        .enable_i    (run_c),
        .cpu_pc_i    (cpu_PC),
        .pc_stable_c (pc_stable_c),
        .changed_c   (changed_c)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        last_chg_d = last_chg_q;
        cyc_d      = cyc_q;
        valid_d    = valid_q;
        halt_c     = cpu_hlt || pc_stable_c;
        // Explicit hlt ends at the current cycle; a stable PC ends at its last change.
        end_cnt_c  = cpu_hlt ? cnt_q : last_chg_q;

        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_d     = '0;
                    cnt_d      = CNT_W'(1);
                    last_chg_d = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (changed_c) begin
                    last_chg_d = cnt_q;
                end
                if (halt_c) begin
                    state_d = ST_DONE;
                    cyc_d   = (end_cnt_c == CNT_MAX) ? CNT_MAX : end_cnt_c + CNT_W'(1);
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_TIMEOUT;
                    cyc_d   = CNT_TOTAL;
                    valid_d = 1'b1;
                end
            end
            default: begin
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                end
            end
        endcase

        cpu_rst_d = (state_d != ST_RUN);
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge input_clk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_q     <= '0;
            cnt_q      <= '0;
            last_chg_q <= '0;
            cyc_q      <= '0;
            valid_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            last_chg_q <= last_chg_d;
            cyc_q      <= cyc_d;
            valid_q    <= valid_d;
            cpu_rst_q  <= cpu_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cpu_rst         = cpu_rst_q;
    assign running         = running_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign cycles_consumed = cyc_q;
    assign result_valid    = valid_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor with a history-based reference model checked every cycle.
module tb_cpu_run_monitor;

    localparam int unsigned MAXC = 50;
    localparam int unsigned RSTC = 2;
    localparam int unsigned HS   = 8;
    localparam int unsigned CW   = 32;

    logic          input_clk;
    logic          rst;
    logic [31:0]   cpu_PC;
    logic          cpu_hlt;
    logic          cpu_rst;
    logic          running;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles_consumed;
    logic          result_valid;
    logic          result_ready;

    int total = 0;
    int bad   = 0;

    cpu_run_monitor #(
        .MAX_CLOCKS   (MAXC),
        .RESET_CYCLES (RSTC),
        .HALT_STABLE  (HS),
        .CNT_W        (CW)
    ) dut (
        .input_clk       (input_clk),
        .rst             (rst),
        .cpu_PC          (cpu_PC),
        .cpu_hlt         (cpu_hlt),
        .cpu_rst         (cpu_rst),
        .running         (running),
        .done            (done),
        .timeout         (timeout),
        .cycles_consumed (cycles_consumed),
        .result_valid    (result_valid),
        .result_ready    (result_ready)
    );

    initial input_clk = 1'b0;
    always #5 input_clk = ~input_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 hold, 1 run, 2 done, 3 timeout; hist[0] is the PC seen at run entry.
    int          phase;
    int          hold_edges;
    int          m_k;
    logic [31:0] hist[$];
    logic [31:0] e_res;
    logic        e_valid;
    logic        s_rst, s_hlt, s_rdy;
    logic [31:0] s_pc;

    function automatic int last_change();
        for (int j = hist.size() - 1; j >= 1; j--) begin
            if (hist[j] != hist[j-1]) return j;
        end
        return 0;
    endfunction

    function automatic bit stable_halt();
        int k;
        k = hist.size() - 1;
        if (k < int'(HS)) return 1'b0;
        for (int j = k - int'(HS); j < k; j++) begin
            if (hist[j] != hist[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        phase      = 0;
        hold_edges = 0;
        e_res      = '0;
        e_valid    = 1'b0;
        forever begin
            @(posedge input_clk);
            s_rst = rst;
            s_hlt = cpu_hlt;
            s_rdy = result_ready;
            s_pc  = cpu_PC;
            if (s_rst) begin
                phase      = 0;
                hold_edges = 0;
                hist.delete();
                e_res      = '0;
                e_valid    = 1'b0;
            end else if (phase == 0) begin
                hold_edges++;
                if (hold_edges == int'(RSTC)) begin
                    phase = 1;
                    hist.delete();
                    hist.push_back(s_pc);
                end
            end else if (phase == 1) begin
                hist.push_back(s_pc);
                m_k = hist.size() - 1;
                if (s_hlt) begin
                    phase = 2; e_res = 32'(m_k + 1); e_valid = 1'b1;
                end else if (stable_halt()) begin
                    phase = 2; e_res = 32'(last_change() + 1); e_valid = 1'b1;
                end else if (m_k == int'(MAXC) - 1) begin
                    phase = 3; e_res = 32'(MAXC); e_valid = 1'b1;
                end
            end else if (e_valid && s_rdy) begin
                e_valid = 1'b0;
            end
            @(negedge input_clk);
            check("cpu_rst", 32'(cpu_rst), 32'(phase != 1));
            check("running", 32'(running), 32'(phase == 1));
            check("done", 32'(done), 32'(phase == 2));
            check("timeout", 32'(timeout), 32'(phase == 3));
            check("cycles_consumed", cycles_consumed, (phase >= 2) ? e_res : 32'd0);
            check("result_valid", 32'(result_valid), 32'(e_valid));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic start_run();
        rst = 1'b1; cpu_hlt = 1'b0; cpu_PC = '0; result_ready = 1'b0;
        repeat (2) @(negedge input_clk);
        rst = 1'b0;
        repeat (2) @(negedge input_clk);
    endtask

    initial begin
        rst = 1'b1; cpu_PC = '0; cpu_hlt = 1'b0; result_ready = 1'b0;

        // Reset release and CPU reset timing
        repeat (3) @(negedge input_clk);
        check("t1_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t1_rst_valid", 32'(result_valid), 32'd0);
        rst = 1'b0;
        @(negedge input_clk);
        check("t1_hold_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t1_hold_running", 32'(running), 32'd0);
        @(negedge input_clk);
        check("t1_run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_run_running", 32'(running), 32'd1);

        // Explicit hlt at cnt=10
        for (int k = 1; k <= 10; k++) begin
            cpu_PC = 32'(4 * k); cpu_hlt = (k == 10);
            @(negedge input_clk);
            if (k == 9) check("t2_not_done_yet", 32'(done), 32'd0);
        end
        cpu_hlt = 1'b0;
        check("t2_done", 32'(done), 32'd1);
        check("t2_cycles", cycles_consumed, 32'd11);
        check("t2_valid", 32'(result_valid), 32'd1);
        check("t2_cpu_rst_frozen", 32'(cpu_rst), 32'd1);

        // Consumer stalls, then accepts once
        for (int i = 0; i < 5; i++) begin
            @(negedge input_clk);
            check("t5_valid_held", 32'(result_valid), 32'd1);
            check("t5_data_held", cycles_consumed, 32'd11);
        end
        result_ready = 1'b1;
        @(negedge input_clk);
        check("t5_valid_drop", 32'(result_valid), 32'd0);
        repeat (3) @(negedge input_clk);
        check("t5_valid_stays_low", 32'(result_valid), 32'd0);
        check("t5_done_sticky", 32'(done), 32'd1);

        // Stall of 3 cycles, last change at cnt=5, then PC holds
        start_run();
        for (int k = 1; k <= 13; k++) begin
            cpu_PC = (k < 5) ? 32'd4 : 32'd8;
            @(negedge input_clk);
            if (k == 12) check("t3_not_done_yet", 32'(done), 32'd0);
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_cycles", cycles_consumed, 32'd6);

        // Watchdog expiry with PC always moving
        start_run();
        for (int k = 1; k <= 49; k++) begin
            cpu_PC = 32'(4 * k);
            @(negedge input_clk);
            if (k == 48) check("t4_no_timeout_yet", 32'(timeout), 32'd0);
        end
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_not_done", 32'(done), 32'd0);
        check("t4_cycles", cycles_consumed, 32'd50);

        // Halt on the watchdog cycle wins
        start_run();
        for (int k = 1; k <= 49; k++) begin
            cpu_PC = 32'(4 * k); cpu_hlt = (k == 49);
            @(negedge input_clk);
        end
        cpu_hlt = 1'b0;
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_no_timeout", 32'(timeout), 32'd0);
        check("t4b_cycles", cycles_consumed, 32'd50);

        // Reset mid-run at cnt=20, then a fresh run
        start_run();
        for (int k = 1; k <= 19; k++) begin
            cpu_PC = 32'(4 * k);
            @(negedge input_clk);
        end
        cpu_PC = 32'd80; rst = 1'b1;
        @(negedge input_clk);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t6_running", 32'(running), 32'd0);
        rst = 1'b0; cpu_PC = '0;
        repeat (2) @(negedge input_clk);
        check("t6_rerun", 32'(running), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            cpu_PC = 32'(4 * k); cpu_hlt = (k == 10);
            @(negedge input_clk);
        end
        cpu_hlt = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        check("t6_cycles", cycles_consumed, 32'd11);

        @(negedge input_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
